ssrv_mem_arbiter: RTL and testbench
===================================

SSRV_MEM_ARBITER -- requirements
Module: ssrv_mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- TIMEOUT, 255, cycles allowed in ISSUE plus WAIT before an error response; 0 disables the timeout.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, reset; synchronous, active-high.
- imem_req, in, 1, instruction request.
- imem_cmd, in, 1, instruction command: 0 = RD, 1 = WR.
- imem_addr, in, AWIDTH, instruction address.
- imem_req_ack, out, 1, instruction grant pulse.
- imem_rdata, out, DWIDTH, instruction read data.
- imem_resp, out, 2, instruction response: 00 = NOTRDY, 01 = RDY_OK, 10 = RDY_ER.
- dmem_req, in, 1, data request.
- dmem_cmd, in, 1, data command.
- dmem_width, in, 2, data access width: 00 = byte, 01 = hword, 10 = word.
- dmem_addr, in, AWIDTH, data address.
- dmem_wdata, in, DWIDTH, data write data.
- dmem_req_ack, out, 1, data grant pulse.
- dmem_rdata, out, DWIDTH, data read data.
- dmem_resp, out, 2, data response.
- mem_req, out, 1, shared-port request.
- mem_cmd, out, 1, shared-port command.
- mem_width, out, 2, shared-port width.
- mem_addr, out, AWIDTH, shared-port address.
- mem_wdata, out, DWIDTH, shared-port write data.
- mem_req_ack, in, 1, shared-port request accepted.
- mem_rdata, in, DWIDTH, shared-port read data.
- mem_resp, in, 2, shared-port response.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have three states, IDLE, ISSUE and WAIT, and SHALL allow at most one outstanding shared-port transaction.
REQ-004 In IDLE, when either request is high, the block SHALL select a requester and move to ISSUE on the next edge.
- On that edge it latches the requester's cmd, addr, wdata and width; for imem, width is forced to 10 (word) and wdata to 0.
REQ-005 Arbitration SHALL be round-robin.
- One requester high: that requester wins.
- Both high: the requester not granted last wins.
- last_grant resets to dmem, so imem wins the first tie.
REQ-006 The granted requester's req_ack SHALL pulse high for exactly one cycle, coincident with the first ISSUE cycle (1-cycle grant latency).
- The ungranted requester sees req_ack = 0 and resp = 00.
REQ-007 In ISSUE, mem_req SHALL be 1 and the mem_* fields SHALL hold the latched values; they are stable until mem_req_ack = 1.
REQ-008 In ISSUE, mem_req_ack = 1 with mem_resp = 00 SHALL move the FSM to WAIT; mem_req is 0 in WAIT.
REQ-009 In ISSUE, mem_req_ack = 1 with mem_resp != 00 in the same cycle SHALL complete the transaction directly and return to IDLE.
REQ-010 In WAIT, mem_resp != 00 SHALL complete the transaction and return to IDLE.
REQ-011 On completion, the granted requester's resp SHALL equal the sampled mem_resp for exactly one cycle (registered, 1 cycle after mem_resp).
- Its rdata equals the sampled mem_rdata in that cycle.
- rdata holds its value after the pulse; resp returns to 00.
REQ-012 An 8-bit-or-wider timeout counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE or WAIT.
- When it reaches TIMEOUT (TIMEOUT != 0), the requester receives resp = 10 and rdata = 0 for one cycle, and the FSM returns to IDLE.
REQ-013 A completion cycle is also an IDLE cycle; a request present in the cycle the FSM returns to IDLE SHALL be arbitrated in that IDLE cycle.
- Minimum back-to-back spacing is therefore 1 IDLE cycle.
REQ-014 Requests asserted while busy = 1 SHALL be ignored (no ack) and stay pending until IDLE.
REQ-015 mem_resp and mem_req_ack values seen in IDLE SHALL be ignored.
REQ-016 A requester cmd other than 0 or 1 (X/invalid) SHALL NOT be forwarded.
- The requester gets req_ack = 1 and, on the following cycle, resp = 10; mem_req stays 0.

Reset
REQ-017 While rst = 1 at a clock edge, the block SHALL apply the reset values:
- state IDLE, last_grant dmem, timeout counter 0;
- mem_req 0 and all mem_* outputs 0;
- both req_ack 0, both resp 00, both rdata 0, busy 0.
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction with no response to the requester; late memory responses after reset fall under REQ-015.

Verification
REQ-019 Single imem read at addr 0x100:
- memory acks in its first ISSUE cycle and returns resp 01, rdata 0x00000013 two cycles later;
- required: imem_req_ack at cycle +1, mem_addr 0x100 with mem_width 10, imem_resp 01 with imem_rdata 0x00000013 one cycle after mem_resp.
REQ-020 imem and dmem both request in the same cycle from reset:
- required: imem is granted first; dmem is granted in the IDLE cycle after imem completes;
- with both held high, grants then alternate imem, dmem, imem, dmem.
REQ-021 dmem write, width 00, addr 0x2003, wdata 0xAB, with mem_req_ack and mem_resp 01 in the same cycle:
- required: FSM goes ISSUE to IDLE, no WAIT cycle;
- dmem_resp 01 for one cycle; mem_width 00 and mem_wdata 0xAB while mem_req = 1.
REQ-022 TIMEOUT = 4, memory never acks:
- required: dmem_resp 10 with dmem_rdata 0 exactly 4 cycles after entering ISSUE;
- busy drops the cycle after the dmem_resp pulse.
REQ-023 rst pulsed in WAIT, then memory returns resp 01:
- required: no requester resp pulse, all outputs at reset values;
- the next imem request is granted normally.

Source files
------------

// File: rtl/ssrv_mem_arbiter_if.sv
// Bundles the imem/dmem requester ports, the shared memory port and busy.
// slave = arbiter side, master = cores plus memory side.
interface ssrv_mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              imem_req;
  logic              imem_cmd;
  logic [AWIDTH-1:0] imem_addr;
  logic              imem_req_ack;
  logic [DWIDTH-1:0] imem_rdata;
  logic [1:0]        imem_resp;

  logic              dmem_req;
  logic              dmem_cmd;
  logic [1:0]        dmem_width;
  logic [AWIDTH-1:0] dmem_addr;
  logic [DWIDTH-1:0] dmem_wdata;
  logic              dmem_req_ack;
  logic [DWIDTH-1:0] dmem_rdata;
  logic [1:0]        dmem_resp;

  logic              mem_req;
  logic              mem_cmd;
  logic [1:0]        mem_width;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_req_ack;
  logic [DWIDTH-1:0] mem_rdata;
  logic [1:0]        mem_resp;

  logic              busy;

  modport slave (
    input  imem_req, imem_cmd, imem_addr,
    output imem_req_ack, imem_rdata, imem_resp,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp,
    output mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
    input  mem_req_ack, mem_rdata, mem_resp,
    output busy
  );

  modport master (
    output imem_req, imem_cmd, imem_addr,
    input  imem_req_ack, imem_rdata, imem_resp,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp,
    input  mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
    output mem_req_ack, mem_rdata, mem_resp,
    input  busy
  );
endinterface

// File: rtl/ssrv_mem_arbiter.sv
// Round-robin imem/dmem arbiter onto one memory port, one transaction in flight.
// Grant 1 cycle after request, response 1 cycle after mem_resp; requests wait while busy.
module ssrv_mem_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  ssrv_mem_arbiter_if.slave bus
);
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_ER     = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;   // 1: dmem was granted last
  logic              sel_q, sel_d;     // 1: dmem owns the transaction
  logic              bad_q, bad_d;
  logic              cmd_q, cmd_d;
  logic [1:0]        width_q, width_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              iack_q, iack_d, dack_q, dack_d;
  logic [1:0]        iresp_q, iresp_d, dresp_q, dresp_d;
  logic [DWIDTH-1:0] irdata_q, irdata_d, drdata_q, drdata_d;

  logic              timed_out, pick_dmem, fire;
  logic [1:0]        fire_resp;
  logic [DWIDTH-1:0] fire_rdata;

  // Only an X/Z command can be invalid; this folds to 0 in two-state hardware.
  function automatic logic cmd_bad(input logic c);
    return (c !== 1'b0) && (c !== 1'b1);
  endfunction

  assign timed_out = TO_EN && (tcnt_q == TMAX);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    bad_d      = bad_q;
    cmd_d      = cmd_q;
    width_d    = width_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tcnt_d     = tcnt_q;
    iack_d     = 1'b0;
    dack_d     = 1'b0;
    iresp_d    = RESP_NOTRDY;
    dresp_d    = RESP_NOTRDY;
    irdata_d   = irdata_q;
    drdata_d   = drdata_q;
    pick_dmem  = 1'b0;
    fire       = 1'b0;
    fire_resp  = RESP_NOTRDY;
    fire_rdata = '0;
    case (state_q)
      IDLE: begin
        if (bus.imem_req || bus.dmem_req) begin
          pick_dmem = bus.dmem_req && (!bus.imem_req || !last_q);
          state_d   = ISSUE;
          last_d    = pick_dmem;
          sel_d     = pick_dmem;
          tcnt_d    = '0;
          if (pick_dmem) begin
            dack_d  = 1'b1;
            bad_d   = cmd_bad(bus.dmem_cmd);
            cmd_d   = bus.dmem_cmd;
            width_d = bus.dmem_width;
            addr_d  = bus.dmem_addr;
            wdata_d = bus.dmem_wdata;
          end else begin
            iack_d  = 1'b1;
            bad_d   = cmd_bad(bus.imem_cmd);
            cmd_d   = bus.imem_cmd;
            width_d = 2'b10;
            addr_d  = bus.imem_addr;
            wdata_d = '0;
          end
        end
      end
      ISSUE, WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (timed_out) begin
          // error response already went out on the previous edge
          state_d = IDLE;
        end else if (bad_q) begin
          fire      = 1'b1;
          fire_resp = RESP_ER;
          state_d   = IDLE;
        end else if ((state_q == ISSUE) && bus.mem_req_ack && (bus.mem_resp == RESP_NOTRDY)) begin
          state_d = WAIT;
        end else if (((state_q == ISSUE) && bus.mem_req_ack) ||
                     ((state_q == WAIT) && (bus.mem_resp != RESP_NOTRDY))) begin
          fire       = 1'b1;
          fire_resp  = bus.mem_resp;
          fire_rdata = bus.mem_rdata;
          state_d    = IDLE;
        end
        if (!fire && !timed_out && TO_EN && (tcnt_d == TMAX)) begin
          fire      = 1'b1;
          fire_resp = RESP_ER;
        end
        if (fire) begin
          if (sel_q) begin
            dresp_d  = fire_resp;
            drdata_d = fire_rdata;
          end else begin
            iresp_d  = fire_resp;
            irdata_d = fire_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      bad_q    <= 1'b0;
      cmd_q    <= 1'b0;
      width_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tcnt_q   <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      iresp_q  <= RESP_NOTRDY;
      dresp_q  <= RESP_NOTRDY;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      bad_q    <= bad_d;
      cmd_q    <= cmd_d;
      width_q  <= width_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tcnt_q   <= tcnt_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      iresp_q  <= iresp_d;
      dresp_q  <= dresp_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.mem_req      = (state_q == ISSUE) && !bad_q && !timed_out;
  assign bus.mem_cmd      = cmd_q;
  assign bus.mem_width    = width_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.imem_req_ack = iack_q;
  assign bus.dmem_req_ack = dack_q;
  assign bus.imem_resp    = iresp_q;
  assign bus.dmem_resp    = dresp_q;
  assign bus.imem_rdata   = irdata_q;
  assign bus.dmem_rdata   = drdata_q;
endmodule

// File: tb/tb_ssrv_mem_arbiter.sv
// Directed bench: stimulus queues expected grants, mem requests and responses;
// a negedge monitor pops and compares whenever the arbiter presents one.
module tb_ssrv_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {int cyc; logic [1:0] resp; logic [31:0] rdata;} rsp_t;
  typedef struct {logic cmd; logic [1:0] width; logic [31:0] addr; logic [31:0] wdata;} memx_t;

  int    iack_q[$];
  int    dack_q[$];
  rsp_t  irsp_q[$];
  rsp_t  drsp_q[$];
  memx_t mem_q[$];
  logic  mem_prev = 1'b0;

  ssrv_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  ssrv_mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=present required=absent (cycle %0d)", name, cyc);
  endtask

  task automatic exp_rsp(input bit dm, input int c, input logic [1:0] r, input logic [31:0] d);
    rsp_t e;
    e.cyc = c; e.resp = r; e.rdata = d;
    if (dm) drsp_q.push_back(e); else irsp_q.push_back(e);
  endtask

  task automatic exp_mem(input logic cm, input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd);
    memx_t m;
    m.cmd = cm; m.width = w; m.addr = a; m.wdata = wd;
    mem_q.push_back(m);
  endtask

  task automatic idle_inputs();
    bus.imem_req = 1'b0; bus.imem_cmd = 1'b0; bus.imem_addr = '0;
    bus.dmem_req = 1'b0; bus.dmem_cmd = 1'b0; bus.dmem_width = 2'b00;
    bus.dmem_addr = '0; bus.dmem_wdata = '0;
    bus.mem_req_ack = 1'b0; bus.mem_rdata = '0; bus.mem_resp = 2'b00;
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_data"}, {bus.imem_rdata, bus.dmem_rdata, bus.mem_addr}, 96'd0);
    chk({name, "_ctl"}, {bus.mem_wdata, 53'd0, bus.busy, bus.mem_req, bus.imem_req_ack,
        bus.dmem_req_ack, bus.imem_resp, bus.dmem_resp, bus.mem_cmd, bus.mem_width}, 96'd0);
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk) begin
    rsp_t  e;
    memx_t m;
    if (bus.imem_req_ack) begin
      if (iack_q.size() == 0) miss("imem_ack_unexpected");
      else chk("imem_ack_cycle", 96'(cyc), 96'(iack_q.pop_front()));
    end
    if (bus.dmem_req_ack) begin
      if (dack_q.size() == 0) miss("dmem_ack_unexpected");
      else chk("dmem_ack_cycle", 96'(cyc), 96'(dack_q.pop_front()));
    end
    if (bus.imem_resp != 2'b00) begin
      if (irsp_q.size() == 0) miss("imem_resp_unexpected");
      else begin
        e = irsp_q.pop_front();
        chk("imem_resp", {32'(cyc), 30'd0, bus.imem_resp, bus.imem_rdata},
            {32'(e.cyc), 30'd0, e.resp, e.rdata});
      end
    end
    if (bus.dmem_resp != 2'b00) begin
      if (drsp_q.size() == 0) miss("dmem_resp_unexpected");
      else begin
        e = drsp_q.pop_front();
        chk("dmem_resp", {32'(cyc), 30'd0, bus.dmem_resp, bus.dmem_rdata},
            {32'(e.cyc), 30'd0, e.resp, e.rdata});
      end
    end
    if (bus.mem_req && !mem_prev) begin
      if (mem_q.size() == 0) miss("mem_req_unexpected");
      else begin
        m = mem_q.pop_front();
        chk("mem_fields", {29'd0, bus.mem_cmd, bus.mem_width, bus.mem_addr, bus.mem_wdata},
            {29'd0, m.cmd, m.width, m.addr, m.wdata});
      end
    end
    mem_prev = bus.mem_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    chk_reset("reset_held");
    rst = 1'b0;
    tick();
    chk_reset("reset_released");

    // Simultaneous requests from reset, memory answers in the ISSUE cycle.
    c = cyc;
    bus.imem_req = 1'b1; bus.imem_cmd = 1'b0; bus.imem_addr = 32'h200;
    bus.dmem_req = 1'b1; bus.dmem_cmd = 1'b1; bus.dmem_width = 2'b01;
    bus.dmem_addr = 32'h3000; bus.dmem_wdata = 32'h1234;
    bus.mem_req_ack = 1'b1; bus.mem_resp = 2'b01;
    for (int k = 0; k < 2; k++) begin
      iack_q.push_back(c + 1 + 4 * k);
      exp_rsp(1'b0, c + 2 + 4 * k, 2'b01, 32'hA000_0000 | 32'(c + 1 + 4 * k));
      exp_mem(1'b0, 2'b10, 32'h200, 32'h0);
      dack_q.push_back(c + 3 + 4 * k);
      exp_rsp(1'b1, c + 4 + 4 * k, 2'b01, 32'hA000_0000 | 32'(c + 3 + 4 * k));
      exp_mem(1'b1, 2'b01, 32'h3000, 32'h1234);
    end
    for (int k = 0; k < 8; k++) begin
      bus.mem_rdata = 32'hA000_0000 | 32'(cyc);
      if (k == 7) begin bus.imem_req = 1'b0; bus.dmem_req = 1'b0; end
      tick();
    end
    idle_inputs();
    tick();
    chk("rr_done_idle", 96'(bus.busy), 96'd0);

    // Single imem read with a WAIT phase; dmem raised while busy.
    c = cyc;
    bus.imem_req = 1'b1; bus.imem_addr = 32'h100;
    iack_q.push_back(c + 1);
    exp_mem(1'b0, 2'b10, 32'h100, 32'h0);
    tick();
    bus.imem_req = 1'b0; bus.mem_req_ack = 1'b1; bus.mem_resp = 2'b00;
    tick();
    chk("wait_no_mem_req", {94'd0, bus.busy, bus.mem_req}, {94'd0, 1'b1, 1'b0});
    bus.mem_req_ack = 1'b0;
    bus.dmem_req = 1'b1; bus.dmem_cmd = 1'b1; bus.dmem_width = 2'b10;
    bus.dmem_addr = 32'h40; bus.dmem_wdata = 32'h77;
    dack_q.push_back(c + 5);
    exp_mem(1'b1, 2'b10, 32'h40, 32'h77);
    tick();
    bus.mem_resp = 2'b01; bus.mem_rdata = 32'h0000_0013;
    exp_rsp(1'b0, c + 4, 2'b01, 32'h0000_0013);
    tick();
    chk("resp_cycle_is_idle", 96'(bus.busy), 96'd0);
    bus.mem_resp = 2'b00; bus.mem_rdata = 32'h0;
    tick();
    bus.dmem_req = 1'b0; bus.mem_req_ack = 1'b1; bus.mem_resp = 2'b01;
    exp_rsp(1'b1, c + 6, 2'b01, 32'h0);
    tick();
    idle_inputs();
    chk("imem_rdata_hold", 96'(bus.imem_rdata), 96'h13);
    tick();

    // Memory handshake noise while idle must be ignored.
    bus.mem_req_ack = 1'b1; bus.mem_resp = 2'b01; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("idle_ignores_mem", {64'd0, 31'd0, bus.busy}, 96'd0);
    idle_inputs();
    tick();

    // dmem byte write completing in ISSUE, no WAIT.
    c = cyc;
    bus.dmem_req = 1'b1; bus.dmem_cmd = 1'b1; bus.dmem_width = 2'b00;
    bus.dmem_addr = 32'h2003; bus.dmem_wdata = 32'hAB;
    dack_q.push_back(c + 1);
    exp_mem(1'b1, 2'b00, 32'h2003, 32'hAB);
    tick();
    bus.dmem_req = 1'b0; bus.mem_req_ack = 1'b1; bus.mem_resp = 2'b01; bus.mem_rdata = 32'h5A5A;
    exp_rsp(1'b1, c + 2, 2'b01, 32'h5A5A);
    tick();
    chk("fast_complete_idle", 96'(bus.busy), 96'd0);
    idle_inputs();
    tick();

    // Timeout: memory never acknowledges.
    c = cyc;
    bus.dmem_req = 1'b1; bus.dmem_cmd = 1'b0; bus.dmem_width = 2'b10;
    bus.dmem_addr = 32'h500; bus.dmem_wdata = 32'h0; bus.mem_rdata = 32'hFFFF_FFFF;
    dack_q.push_back(c + 1);
    exp_mem(1'b0, 2'b10, 32'h500, 32'h0);
    exp_rsp(1'b1, c + 5, 2'b10, 32'h0);
    tick();
    bus.dmem_req = 1'b0;
    repeat (4) tick();
    chk("timeout_busy_during_pulse", 96'(bus.busy), 96'd1);
    tick();
    chk("timeout_busy_after_pulse", 96'(bus.busy), 96'd0);
    idle_inputs();
    tick();

    // Reset in WAIT, then a late memory response.
    bus.imem_req = 1'b1; bus.imem_addr = 32'h300;
    iack_q.push_back(cyc + 1);
    exp_mem(1'b0, 2'b10, 32'h300, 32'h0);
    tick();
    bus.imem_req = 1'b0; bus.mem_req_ack = 1'b1; bus.mem_resp = 2'b00;
    tick();
    bus.mem_req_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_resp = 2'b01; bus.mem_rdata = 32'h77;
    tick();
    chk_reset("reset_mid_wait");
    idle_inputs();
    c = cyc;
    bus.imem_req = 1'b1; bus.imem_addr = 32'h400;
    iack_q.push_back(c + 1);
    exp_mem(1'b0, 2'b10, 32'h400, 32'h0);
    tick();
    bus.imem_req = 1'b0; bus.mem_req_ack = 1'b1; bus.mem_resp = 2'b01; bus.mem_rdata = 32'h99;
    exp_rsp(1'b0, c + 2, 2'b01, 32'h99);
    tick();
    idle_inputs();
    repeat (3) tick();

    chk("queues_drained", 96'(iack_q.size() + dack_q.size() + irsp_q.size() +
        drsp_q.size() + mem_q.size()), 96'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
